// File: rtl/cmm_pkg.sv
// Shared definitions for the complex 2x2 matrix loader/transmitter pair:
// default widths, stream FSM states and the (row, col, imag) element ordering.
package cmm_pkg;

  localparam int CMM_DATA_W = 19;
  localparam int CMM_ACC_W  = 40;
  localparam int CMM_FRAC   = 16;
  localparam int CMM_ELEMS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } cmm_state_t;

  typedef logic [2:0] elem_idx_t;

  // imag is innermost, then col, then row
  function automatic elem_idx_t elem_index(input logic row, input logic col, input logic imag);
    return {row, col, imag};
  endfunction

endpackage

// File: rtl/fixed_point_narrow.sv
// Round-half-up and saturate one signed accumulator word down to the
// signed operand width.
module fixed_point_narrow #(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 19,
  parameter int FRAC   = 16
) (
  input  logic signed [ACC_W-1:0]  x,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) << (FRAC-1);
  localparam logic signed [ACC_W:0] MAX_T = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_T = ~MAX_T;

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] t;

  always_comb begin
    // one extra bit so adding the rounding half can never wrap
    sum = {x[ACC_W-1], x} + HALF;
    t   = sum >>> FRAC;
    sat = 1'b0;
    y   = t[DATA_W-1:0];
    if (t > MAX_T) begin
      y   = {1'b0, {(DATA_W-1){1'b1}}};
      sat = 1'b1;
    end else if (t < MIN_T) begin
      y   = {1'b1, {(DATA_W-1){1'b0}}};
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/complex_matrix_result_transmitter.sv
// Captures the 2x2 complex result matrix in one load, narrows each element,
// and streams the eight words out with row/col/imag tags over a valid/ready port.
module complex_matrix_result_transmitter
  import cmm_pkg::*;
#(
  parameter int DATA_W = CMM_DATA_W,
  parameter int ACC_W  = CMM_ACC_W,
  parameter int FRAC   = CMM_FRAC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CMM_ELEMS*ACC_W-1:0] result_in,
  input  logic                       result_valid,
  output logic                       load_ready,
  output logic signed [DATA_W-1:0]   matrix_out,
  output logic                       out_row,
  output logic                       out_col,
  output logic                       out_imag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       done,
  output logic                       sat_flag
);

  localparam elem_idx_t LAST_IDX = elem_index(1'b1, 1'b1, 1'b1);

  logic signed [DATA_W-1:0] narrow_word [CMM_ELEMS];
  logic [CMM_ELEMS-1:0]     narrow_sat;

  genvar gi;
  generate
    for (gi = 0; gi < CMM_ELEMS; gi++) begin : g_narrow
      fixed_point_narrow #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W),
        .FRAC  (FRAC)
      ) u_narrow (
        .x  (result_in[gi*ACC_W +: ACC_W]),
        .y  (narrow_word[gi]),
        .sat(narrow_sat[gi])
      );
    end
  endgenerate

  cmm_state_t               state_reg, state_next;
  elem_idx_t                index_reg, index_next;
  logic signed [DATA_W-1:0] word_reg [CMM_ELEMS];
  logic                     sat_reg;
  logic                     load_en;

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    load_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (result_valid) begin
          load_en    = 1'b1;
          index_next = '0;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (index_reg == LAST_IDX) state_next = ST_DONE;
          else                       index_next = index_reg + 3'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      index_reg <= '0;
      sat_reg   <= 1'b0;
      for (int i = 0; i < CMM_ELEMS; i++) word_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      if (load_en) begin
        sat_reg <= |narrow_sat;
        for (int i = 0; i < CMM_ELEMS; i++) word_reg[i] <= narrow_word[i];
      end
    end
  end

  // every output is a pure function of registers, so out_ready never reaches them
  always_comb begin
    load_ready = (state_reg == ST_IDLE);
    out_valid  = (state_reg == ST_SEND);
    done       = (state_reg == ST_DONE);
    sat_flag   = sat_reg;
    matrix_out = out_valid ? word_reg[index_reg] : '0;
    out_row    = out_valid & index_reg[2];
    out_col    = out_valid & index_reg[1];
    out_imag   = out_valid & index_reg[0];
    out_last   = out_valid & (index_reg == LAST_IDX);
  end

endmodule

// File: tb/tb_complex_matrix_result_transmitter.sv
// Directed bench: a queue-based reference of the stream is checked every cycle,
// and literal word lists pin each scenario.
module tb_complex_matrix_result_transmitter;

  localparam int DW = 19;
  localparam int AW = 40;
  localparam int FR = 16;
  localparam longint MAXV = (longint'(1) << (DW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW-1));

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [8*AW-1:0]      result_in = '0;
  logic                 result_valid = 1'b0;
  logic                 load_ready;
  logic signed [DW-1:0] matrix_out;
  logic                 out_row, out_col, out_imag, out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_last, done, sat_flag;

  always #5 clk = ~clk;

  complex_matrix_result_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .result_in   (result_in),
    .result_valid(result_valid),
    .load_ready  (load_ready),
    .matrix_out  (matrix_out),
    .out_row     (out_row),
    .out_col     (out_col),
    .out_imag    (out_imag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .done        (done),
    .sat_flag    (sat_flag)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int first_valid_cyc = 0;
  int done_cyc = 0;
  int done_count = 0;

  longint exp_q[$];
  longint seen[$];
  bit     done_pend = 1'b0;
  bit     sat_exp = 1'b0;
  bit     stall_prev = 1'b0;
  longint prev_word = 0;
  longint prev_tag = 0;
  longint el [8];
  longint lit [8];

  function automatic longint narrow_val(input longint x);
    longint t;
    t = (x + (longint'(1) << (FR-1))) >>> FR;
    if (t > MAXV) return MAXV;
    if (t < MINV) return MINV;
    return t;
  endfunction

  function automatic bit narrow_sat(input longint x);
    longint t;
    t = (x + (longint'(1) << (FR-1))) >>> FR;
    return (t > MAXV) || (t < MINV);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference: a loaded matrix becomes 8 queued words, one popped per handshake
  always @(negedge clk) begin
    bit     idle_m;
    bit     any_sat;
    int     pos;
    longint x;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      done_pend  = 1'b0;
      sat_exp    = 1'b0;
      stall_prev = 1'b0;
      chk("rst_load_ready", longint'(load_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_sat_flag", longint'(sat_flag), 0);
      chk("rst_matrix_out", longint'(matrix_out), 0);
    end else begin
      idle_m = (exp_q.size() == 0) && !done_pend;
      chk("done", longint'(done), longint'(done_pend));
      if (done === 1'b1) begin
        done_cyc = cyc;
        done_count++;
      end
      done_pend = 1'b0;
      chk("out_valid", longint'(out_valid), longint'(exp_q.size() != 0));
      chk("load_ready", longint'(load_ready), longint'(idle_m));
      chk("sat_flag", longint'(sat_flag), longint'(sat_exp));
      if (exp_q.size() != 0) begin
        pos = 8 - exp_q.size();
        chk("word", longint'(matrix_out), exp_q[0]);
        chk("tag", longint'({out_row, out_col, out_imag}), longint'(pos));
        chk("last", longint'(out_last), longint'(pos == 7));
        if (stall_prev) begin
          chk("stall_word", longint'(matrix_out), prev_word);
          chk("stall_tag", longint'({out_row, out_col, out_imag}), prev_tag);
        end else if (pos == 0) begin
          first_valid_cyc = cyc;
        end
        prev_word  = longint'(matrix_out);
        prev_tag   = longint'({out_row, out_col, out_imag});
        stall_prev = !out_ready;
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen.push_back(longint'(matrix_out));
          $display("xfer k=%0d row=%0b col=%0b imag=%0b word=%0d last=%0b",
                   pos, out_row, out_col, out_imag, matrix_out, out_last);
          if (pos == 7) done_pend = 1'b1;
        end
      end else begin
        stall_prev = 1'b0;
      end
      if (idle_m && result_valid) begin
        any_sat = 1'b0;
        for (int k = 0; k < 8; k++) begin
          x = longint'($signed(result_in[k*AW +: AW]));
          exp_q.push_back(narrow_val(x));
          any_sat |= narrow_sat(x);
        end
        sat_exp = any_sat;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int k = 0; k < 8; k++) result_in[k*AW +: AW] = el[k][AW-1:0];
  endtask

  task automatic load();
    int i;
    for (i = 0; i < 50; i++) begin
      if (load_ready === 1'b1) break;
      step();
    end
    if (load_ready !== 1'b1) chk("load_wait_timeout", 0, 1);
    pack();
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
  endtask

  // returns one cycle after the done pulse so the reference has seen it
  task automatic wait_done();
    int i;
    for (i = 0; i < 100; i++) begin
      if (done === 1'b1) break;
      step();
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
    step();
  endtask

  task automatic check_seen(input string name, input longint ex [8]);
    chk({name, "_count"}, longint'(seen.size()), 8);
    for (int i = 0; i < 8; i++)
      chk(name, (i < seen.size()) ? seen[i] : -999999, ex[i]);
  endtask

  initial begin
    int dc;
    out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();

    // basic stream
    for (int k = 0; k < 8; k++) el[k] = longint'(k) * 65536;
    seen.delete();
    load();
    wait_done();
    lit = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_seen("basic", lit);
    chk("basic_span", longint'(done_cyc - first_valid_cyc), 8);
    chk("basic_sat", longint'(sat_flag), 0);

    // rounding
    el = '{32767, 32768, -32768, -32769, 98304, -98305, 0, 65535};
    seen.delete();
    load();
    wait_done();
    lit = '{0, 1, 0, -1, 2, -2, 0, 1};
    check_seen("round", lit);

    // saturation, then cleared by a clean load
    el = '{262144 * 65536, -262145 * 65536, 0, 0, 0, 0, 0, 0};
    seen.delete();
    load();
    wait_done();
    lit = '{262143, -262144, 0, 0, 0, 0, 0, 0};
    check_seen("sat", lit);
    chk("sat_set", longint'(sat_flag), 1);
    for (int k = 0; k < 8; k++) el[k] = 0;
    load();
    chk("sat_clear", longint'(sat_flag), 0);
    wait_done();

    // backpressure at index 2 for three cycles
    for (int k = 0; k < 8; k++) el[k] = longint'(k) * 3 * 65536;
    seen.delete();
    load();
    step();
    step();
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    wait_done();
    lit = '{0, 3, 6, 9, 12, 15, 18, 21};
    check_seen("bp", lit);
    chk("bp_span", longint'(done_cyc - first_valid_cyc), 11);

    // load attempt during SEND is ignored
    for (int k = 0; k < 8; k++) el[k] = longint'(10 + k) * 65536;
    seen.delete();
    load();
    repeat (4) step();
    for (int k = 0; k < 8; k++) el[k] = longint'(100 + k) * 65536;
    pack();
    result_valid = 1'b1;
    chk("busy_load_ready", longint'(load_ready), 0);
    step();
    result_valid = 1'b0;
    wait_done();
    lit = '{10, 11, 12, 13, 14, 15, 16, 17};
    check_seen("busy", lit);

    // reset mid-stream at index 5
    for (int k = 0; k < 8; k++) el[k] = longint'(k) * 65536;
    seen.delete();
    load();
    repeat (5) step();
    reset = 1'b0;
    step();
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_load_ready", longint'(load_ready), 1);
    reset = 1'b1;
    dc = done_count;
    repeat (12) step();
    chk("mid_rst_no_done", longint'(done_count - dc), 0);
    chk("mid_rst_words", longint'(seen.size()), 5);
    chk("mid_rst_last_word", (seen.size() == 5) ? seen[4] : -999999, 4);

    // fresh load after reset
    for (int k = 0; k < 8; k++) el[k] = longint'(20 + k) * 65536 - 1;
    seen.delete();
    load();
    wait_done();
    lit = '{20, 21, 22, 23, 24, 25, 26, 27};
    check_seen("fresh", lit);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_matrix_result_transmitter.md
Name: complex_matrix_result_transmitter

Overview:
Output-side counterpart of the matrix loader. Captures the 2x2 complex result matrix from the multiplier core in one parallel load. Rounds and saturates each wide accumulator word back to the 19-bit signed operand format. Streams the eight words out one per handshake, tagged with row/col/imag in the same order the operands were loaded in: row, then col, then imag innermost.

Parameters:
DATA_W, 19, width of each output word (signed; same format as matrix_in)
ACC_W, 40, width of each signed accumulator word from the core
FRAC, 16, fractional bits removed on narrowing (arithmetic right shift amount, FRAC >= 1)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-low
result_in  in  8*ACC_W  flattened result; element k = row*4 + col*2 + imag at bits [k*ACC_W +: ACC_W]
result_valid  in  1  result_in valid; accepted only when load_ready=1
load_ready  out  1  high in IDLE
matrix_out  out  DATA_W  current output word
out_row  out  1  row tag of matrix_out
out_col  out  1  column tag
out_imag  out  1  1 = imaginary part, 0 = real part
out_valid  out  1  matrix_out and tags valid
out_ready  in  1  consumer accepts word when out_valid && out_ready
out_last  out  1  high with the word at k=7
done  out  1  one-cycle pulse after final transfer
sat_flag  out  1  sticky: some element of the current matrix saturated

Behaviour:
- Reset (reset=0, async): state=IDLE, index=0, word registers=0, sat_flag=0; load_ready=1, all other outputs 0.
- States: IDLE, SEND, DONE.
- IDLE:
  - load_ready=1, out_valid=0.
  - On a clock edge with result_valid=1: capture all 8 narrowed words, set sat_flag = OR of the 8 saturation bits (replacing the old value), index=0, go to SEND.
- SEND:
  - out_valid=1; matrix_out=word[index]; out_row=index[2]; out_col=index[1]; out_imag=index[0]; out_last=(index==7).
  - On out_valid && out_ready: if index==7 go to DONE, else index++.
  - Without out_ready, all outputs hold stable (no change while stalled).
  - result_valid is ignored.
- DONE: done=1 for exactly one cycle; out_valid=0; go to IDLE. sat_flag holds until the next load.
- Latency:
  - result_valid sampled at edge n -> out_valid=1 from edge n.
  - With out_ready tied high: 8 consecutive transfers, done pulses on the cycle after the 8th transfer, load_ready returns one cycle after done.
  - Minimum interval between loads: 10 cycles.
- Narrowing (per element, x = signed ACC_W):
  - t = (x + 2^(FRAC-1)), computed in ACC_W+1 bits, then arithmetic right shift by FRAC (round half up).
  - If t > 2^(DATA_W-1)-1, output 262143 and set sat. If t < -2^(DATA_W-1), output -262144 and set sat. Otherwise output t.
- Boundary conditions:
  - Reset mid-stream abandons the stream: no done, no further words.
  - result_valid and out_ready are independent; no combinational path from out_ready to any output.

Decomposition:
- Package cmm_pkg:
  - DATA_W/ACC_W/FRAC defaults.
  - State enum {IDLE, SEND, DONE}.
  - Element index type (3 bits).
  - Function mapping (row, col, imag) to index. The loader uses the same function.
- Sub-module fixed_point_narrow (ACC_W, DATA_W, FRAC): combinational round + saturate, outputs word and sat bit. Instantiated 8 times at the load boundary.

Test Plan:
- Basic stream: load elements k=0..7 = k*65536, out_ready=1 -> matrix_out 0..7 on 8 consecutive cycles, tags (0,0,0)..(1,1,1), out_last only on 8th, done pulse next cycle, sat_flag=0.
- Rounding: elements 32767, 32768, -32768, -32769, 98304, -98305, 0, 65535 -> outputs 0, 1, 0, -1, 2, -2, 0, 1.
- Saturation: element0 = 262144*65536, element1 = -262145*65536, rest 0 -> outputs 262143, -262144, sat_flag=1. The next load with all zeros clears sat_flag to 0.
- Backpressure: drop out_ready for 3 cycles while index=2 -> matrix_out/tags/out_valid stable for those cycles. Total 11 cycles from first out_valid to done. No word is duplicated or skipped.
- Load during SEND: pulse result_valid with different data at index=4 -> ignored, remaining words come from the original matrix, load_ready stays 0.
- Reset mid-stream: assert reset at index=5 -> out_valid=0, load_ready=1, done never pulses. A fresh load afterwards streams from index 0 correctly.
